// File: rtl/timer_ctrl_pkg.sv
// Shared types for the timer controller: command opcodes, FSM states and the
// legality table that decides which op/state pairs are honoured.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_PAUSE  = 2'd1,
    OP_RESUME = 2'd2,
    OP_ABORT  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_REP_W = 4;

  // START is only meaningful with a non-zero repetition count.
  function automatic logic cmd_is_legal(input state_t st, input op_t op, input logic reps_nz);
    logic ok;
    ok = 1'b0;
    case (st)
      S_IDLE:  ok = (op == OP_START) && reps_nz;
      S_RUN:   ok = (op == OP_PAUSE) || (op == OP_ABORT);
      S_PAUSE: ok = (op == OP_RESUME) || (op == OP_ABORT);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/timer_ctrl_counter.sv
// Modulo up-counter 0..limit; clear beats enable, wraps to zero at the limit.
module mod_counter
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign at_limit = (count_q == limit);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_limit ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Command-driven sequencer running a modulo counter through a number of wraps;
// owns counter enable/clear and reports wrap, done and error events.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int REP_W = DEFAULT_REP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [REP_W-1:0] cmd_reps,
  output logic [WIDTH-1:0] count,
  output logic [REP_W-1:0] rep_count,
  output logic             busy,
  output logic             paused,
  output logic             wrap_pulse,
  output logic             done_pulse,
  output logic             err_pulse
);

  state_t           state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             cnt_en;
  logic             cnt_clr;
  logic             at_limit;
  logic [WIDTH-1:0] cnt_value;

  op_t              op;
  logic             accept;
  logic             legal;
  logic             run_wrap;
  logic             final_wrap;
  logic [REP_W-1:0] rep_inc;

  mod_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .limit    (limit_q),
    .count    (cnt_value),
    .at_limit (at_limit)
  );

  assign op         = op_t'(cmd_op);
  assign cmd_ready  = (state_q != S_DONE);
  assign accept     = cmd_valid && cmd_ready;
  assign legal      = cmd_is_legal(state_q, op, |cmd_reps);
  assign rep_inc    = rep_q + REP_W'(1);
  assign run_wrap   = (state_q == S_RUN) && at_limit;
  assign final_wrap = run_wrap && (rep_inc == reps_q);

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    limit_d = limit_q;
    reps_d  = reps_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;

    // The wrap for this cycle is booked before any command is applied.
    if (run_wrap) begin
      rep_d  = rep_inc;
      wrap_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (legal) begin
            limit_d = cmd_limit;
            reps_d  = cmd_reps;
            rep_d   = '0;
            cnt_clr = 1'b1;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        cnt_en = 1'b1;
        if (final_wrap) begin
          // Completion wins; a legal PAUSE/ABORT is silently dropped.
          state_d = S_DONE;
          if (accept && !legal) begin
            err_d = 1'b1;
          end
        end else if (accept) begin
          if (!legal) begin
            err_d = 1'b1;
          end else if (op == OP_PAUSE) begin
            state_d = S_PAUSE;
          end else begin
            rep_d   = '0;
            cnt_clr = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_PAUSE: begin
        if (accept) begin
          if (!legal) begin
            err_d = 1'b1;
          end else if (op == OP_RESUME) begin
            state_d = S_RUN;
          end else begin
            rep_d   = '0;
            cnt_clr = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rep_q   <= '0;
      limit_q <= '0;
      reps_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      limit_q <= limit_d;
      reps_q  <= reps_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count      = cnt_value;
  assign rep_count  = rep_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign paused     = (state_q == S_PAUSE);
  assign done_pulse = (state_q == S_DONE);
  assign wrap_pulse = wrap_q;
  assign err_pulse  = err_q;

endmodule
